// File: rtl/psg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | psg_pkg : shared PSG envelope register map and shape bit layout |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package psg_pkg;

  localparam logic [1:0] ENV_PER_LO = 2'd0;
  localparam logic [1:0] ENV_PER_HI = 2'd1;
  localparam logic [1:0] ENV_SHAPE  = 2'd2;
  localparam logic [1:0] ENV_LEVEL  = 2'd3;

  localparam int CONT = 3;
  localparam int ATT  = 2;
  localparam int ALT  = 1;
  localparam int HOLD = 0;

  typedef struct packed {
    logic cont;
    logic att;
    logic alt;
    logic hold;
  } env_shape_t;

endpackage
`default_nettype wire

// File: rtl/psg_env_timer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | psg_env_timer : cen prescaler plus envelope period counter      |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module psg_env_timer #(
  parameter int PRE_DIV  = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick,
  output logic                step,
  output logic                null_period
);

  localparam int              PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                step_q, step_d;
  logic                null_q;
  logic [PERIOD_W:0]   cnt_inc;
  logic                expire;

  assign tick    = cen && (pre_q == PRE_MAX);
  assign cnt_inc = {1'b0, cnt_q} + (PERIOD_W+1)'(1);
  // >= rather than == so a period lowered below cnt expires at once
  assign expire  = tick && (period != '0) && (cnt_inc >= {1'b0, period});

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    step_d = step_q;
    if (cen) begin
      pre_d  = tick ? '0 : pre_q + 1'b1;
      step_d = expire && !clear;
    end
    if (tick && (period != '0)) begin
      cnt_d = expire ? '0 : cnt_inc[PERIOD_W-1:0];
    end
    if (clear) begin
      pre_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
      null_q <= 1'b1;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      null_q <= (period == '0);
    end
  end

  assign step        = step_q;
  assign null_period = null_q;

endmodule
`default_nettype wire

// File: rtl/psg_env_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | psg_env_seq : envelope register port, restart and step sequencer|
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module psg_env_seq
  import psg_pkg::*;
#(
  parameter int PRE_DIV  = 8,
  parameter int PERIOD_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  input  logic [4:0] env_in,
  output logic       step,
  output logic       null_period,
  output logic       restart,
  output logic [3:0] ctrl
);

  logic [PERIOD_W-1:0] period_q, period_d;
  env_shape_t          shape_q, shape_d;
  logic                restart_q;
  logic                ack_q;
  logic [7:0]          rdata_q, rdata_d;
  logic [15:0]         per16, per16_wr;
  logic                shape_wr;
  logic                w_tick;

  // Byte view of the period; bits above PERIOD_W read as zero
  assign per16    = 16'(period_q);
  assign shape_wr = wr_en && (addr == ENV_SHAPE);

  always_comb begin
    per16_wr = per16;
    if (wr_en && (addr == ENV_PER_LO)) per16_wr[7:0]  = wdata;
    if (wr_en && (addr == ENV_PER_HI)) per16_wr[15:8] = wdata;
    period_d = PERIOD_W'(per16_wr);
    shape_d  = shape_wr ? env_shape_t'(wdata[3:0]) : shape_q;
    rdata_d  = '0;
    if (rd_en && !wr_en) begin
      case (addr)
        ENV_PER_LO: rdata_d = per16[7:0];
        ENV_PER_HI: rdata_d = per16[15:8];
        ENV_SHAPE:  rdata_d = {4'b0, shape_q};
        default:    rdata_d = {3'b0, env_in};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= '0;
      shape_q   <= '0;
      restart_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      period_q  <= period_d;
      shape_q   <= shape_d;
      restart_q <= shape_wr;
      ack_q     <= wr_en || rd_en;
      rdata_q   <= rdata_d;
    end
  end

  psg_env_timer #(
    .PRE_DIV  (PRE_DIV),
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .clear       (shape_wr),
    .period      (period_q),
    .tick        (w_tick),
    .step        (step),
    .null_period (null_period)
  );

  assign rdata      = rdata_q;
  assign ack        = ack_q;
  assign restart    = restart_q;
  assign ctrl[CONT] = shape_q.cont;
  assign ctrl[ATT]  = shape_q.att;
  assign ctrl[ALT]  = shape_q.alt;
  assign ctrl[HOLD] = shape_q.hold;

endmodule
`default_nettype wire

// File: tb/tb_psg_env_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_psg_env_seq : scoreboard bench for the envelope sequencer    |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_psg_env_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic [4:0] env_in;
  logic       step;
  logic       null_period;
  logic       restart;
  logic [3:0] ctrl;

  psg_env_seq #(.PRE_DIV(8), .PERIOD_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ack         (ack),
    .env_in      (env_in),
    .step        (step),
    .null_period (null_period),
    .restart     (restart),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         chk_data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   rises[$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   cen_div3 = 1'b0;
  int   ph       = 0;
  int   r0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (cen_div3) begin
      ph  = (ph == 2) ? 0 : ph + 1;
      cen = (ph == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every ack must match the oldest outstanding access
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got ack=1 at cycle %0d expected none", cycle);
      end else begin
        e = exp_q.pop_front();
        chk("ack_latency", cycle, e.cyc);
        if (e.chk_data) chk("rdata", {24'b0, rdata}, {24'b0, e.data});
      end
    end
  end

  task automatic acc(input bit w, input bit r, input logic [1:0] a, input logic [7:0] d,
                     input logic [7:0] exp_data, input bit chk_data);
    exp_t e;
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    e.data = exp_data; e.chk_data = chk_data; e.cyc = cycle + 1;
    exp_q.push_back(e);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic watch(input int n);
    logic prev;
    rises.delete();
    prev = step;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step === 1'b1 && prev !== 1'b1) rises.push_back(cycle);
      prev = step;
    end
  endtask

  function automatic int rise_at(input int i);
    return (i < rises.size()) ? rises[i] : -1;
  endfunction

  initial begin
    logic [7:0] rb_exp [4];
    int         t;
    rb_exp = '{8'hAB, 8'hCD, 8'h0D, 8'h15};
    rst_n = 1'b0; cen = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = 2'd0; wdata = 8'h00; env_in = 5'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_null", null_period, 1);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_step", step, 0);
    chk("rst_restart", restart, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);

    // Step rate: period 3, PRE_DIV 8, cen held high
    cen = 1'b1;
    acc(1, 0, 2'd0, 8'h03, 8'h00, 0);
    chk("per_wr_no_restart", restart, 0);
    chk("null_at_ack", null_period, 1);
    @(negedge clk);
    chk("null_after_ack", null_period, 0);
    acc(1, 0, 2'd1, 8'h00, 8'h00, 0);
    acc(1, 0, 2'd2, 8'h0E, 8'h00, 0);
    chk("shape_restart", restart, 1);
    chk("shape_ctrl", ctrl, 4'hE);
    r0 = cycle;
    @(negedge clk);
    chk("restart_one_cycle", restart, 0);
    watch(79);
    chk("step_first", rise_at(0), r0 + 24);
    chk("step_second", rise_at(1), r0 + 48);
    chk("step_third", rise_at(2), r0 + 72);

    // Period shrink: 100 -> 10 with cnt at 50
    acc(1, 0, 2'd0, 8'd100, 8'h00, 0);
    acc(1, 0, 2'd2, 8'h0E, 8'h00, 0);
    r0 = cycle;
    watch(402);
    chk("shrink_no_early_step", rises.size(), 0);
    acc(1, 0, 2'd0, 8'd10, 8'h00, 0);
    watch(180);
    chk("shrink_next_tick", rise_at(0), r0 + 408);
    chk("shrink_then_10", rise_at(1), r0 + 488);
    chk("shrink_then_20", rise_at(2), r0 + 568);

    // Readback with back-to-back reads
    env_in = 5'h15;
    acc(1, 0, 2'd0, 8'hAB, 8'h00, 0);
    acc(1, 0, 2'd1, 8'hCD, 8'h00, 0);
    acc(1, 0, 2'd2, 8'h0D, 8'h00, 0);
    acc(1, 0, 2'd3, 8'hFF, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      @(negedge clk);
      rd_en = 1'b1; addr = 2'(i);
      e.data = rb_exp[i]; e.chk_data = 1'b1; e.cyc = cycle + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);

    // Collision: write wins, single ack with zero data
    acc(1, 1, 2'd2, 8'h09, 8'h00, 1);
    chk("coll_ctrl", ctrl, 4'h9);
    chk("coll_restart", restart, 1);
    @(negedge clk);
    chk("coll_restart_low", restart, 0);

    // Reset while step is high, cen at 1/3 rate
    acc(1, 0, 2'd1, 8'h00, 8'h00, 0);
    acc(1, 0, 2'd0, 8'h02, 8'h00, 0);
    acc(1, 0, 2'd2, 8'h00, 8'h00, 0);
    cen_div3 = 1'b1;
    t = 0;
    while (step !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("mid_step_seen", step, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_step", step, 0);
    chk("mid_rst_null", null_period, 1);
    chk("mid_rst_ctrl", ctrl, 0);
    chk("mid_rst_ack", ack, 0);
    cen_div3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
